// File: rtl/bank_read_controller.sv
// Single-outstanding read controller for four banks with a fixed read latency.
// A request is latched, issued as a one-cycle strobe, and the result is held until accepted.
module bank_read_controller #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic [1:0]            bank_select,
  output logic                  read_enable,
  output logic [ADDR_WIDTH-3:0] bank_addr,
  input  logic [DATA_WIDTH-1:0] bank01_rdata,
  input  logic [DATA_WIDTH-1:0] bank02_rdata,
  input  logic [DATA_WIDTH-1:0] bank03_rdata,
  input  logic [DATA_WIDTH-1:0] bank04_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_bank
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

  state_t                state;
  state_t                state_next;
  logic [3:0]            cnt;
  logic                  accept;
  logic                  cnt_done;
  logic [DATA_WIDTH-1:0] sel_rdata;

  assign accept   = (state == IDLE) && req_valid;
  assign cnt_done = (state == WAIT) && (cnt == 4'd0);

  lat_legal: assert property (@(posedge clk)
    (READ_LATENCY >= 1) && (READ_LATENCY <= 15));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (req_valid) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT:  if (cnt == 4'd0) state_next = RESP;
      RESP:  if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): req_ready = 1'b1;
      (state == RESP): rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Strobe is a flop so the bank decoder never sees a decode glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_enable <= 1'b0;
    end else begin
      read_enable <= (state_next == ISSUE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_select <= '0;
      bank_addr   <= '0;
    end else if (accept) begin
      bank_select <= req_addr[ADDR_WIDTH-1:ADDR_WIDTH-2];
      bank_addr   <= req_addr[ADDR_WIDTH-3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (state == ISSUE) begin
      cnt <= CNT_LOAD;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    sel_rdata = '0;
    unique case (bank_select)
      2'd0: sel_rdata = bank01_rdata;
      2'd1: sel_rdata = bank02_rdata;
      2'd2: sel_rdata = bank03_rdata;
      2'd3: sel_rdata = bank04_rdata;
      default: sel_rdata = '0;
    endcase
  end

  // Mux on the latched bank, never on the live request address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_bank <= '0;
    end else if (cnt_done) begin
      rsp_data <= sel_rdata;
      rsp_bank <= bank_select;
    end
  end

endmodule

// File: tb/tb_bank_read_controller.sv
// Directed bench for bank_read_controller: table vectors, stall, reset
// abort, and latency/spacing checks on READ_LATENCY=1 and 15 builds.
module tb_bank_read_controller;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_addr;
  logic [1:0]  bank_select;
  logic        read_enable;
  logic [7:0]  bank_addr;
  logic [31:0] b0, b1, b2, b3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_bank;

  logic        rv1, rr1, rv15, rr15;
  logic        rdy1, rdy15, re1, re15, vl1, vl15;
  logic [9:0]  ra1, ra15;
  logic [1:0]  bs1, bs15, rb1, rb15;
  logic [7:0]  ba1, ba15;
  logic [31:0] rd1, rd15;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] d0, d1, d2, d3;
    logic [1:0]  bank;
    logic [7:0]  baddr;
    logic [31:0] data;
    int          stall;
  } vec_t;

  vec_t vt[5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bank_read_controller #(.READ_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .bank_select(bank_select), .read_enable(read_enable),
    .bank_addr(bank_addr),
    .bank01_rdata(b0), .bank02_rdata(b1),
    .bank03_rdata(b2), .bank04_rdata(b3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_bank(rsp_bank)
  );

  bank_read_controller #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv1), .req_ready(rdy1), .req_addr(ra1),
    .bank_select(bs1), .read_enable(re1), .bank_addr(ba1),
    .bank01_rdata(b0), .bank02_rdata(b1),
    .bank03_rdata(b2), .bank04_rdata(b3),
    .rsp_valid(vl1), .rsp_ready(rr1),
    .rsp_data(rd1), .rsp_bank(rb1)
  );

  bank_read_controller #(.READ_LATENCY(15)) dut15 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv15), .req_ready(rdy15), .req_addr(ra15),
    .bank_select(bs15), .read_enable(re15), .bank_addr(ba15),
    .bank01_rdata(b0), .bank02_rdata(b1),
    .bank03_rdata(b2), .bank04_rdata(b3),
    .rsp_valid(vl15), .rsp_ready(rr15),
    .rsp_data(rd15), .rsp_bank(rb15)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic set_banks(input vec_t v);
    b0 = v.d0;
    b1 = v.d1;
    b2 = v.d2;
    b3 = v.d3;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    set_banks(v);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = v.addr;
    @(posedge clk);
    #1;
    // Request accepted; scramble the live address and keep req_valid high
    req_addr = ~v.addr;
    chk("issue_re", read_enable, 1);
    chk("issue_rdy", req_ready, 0);
    chk("issue_bsel", bank_select, v.bank);
    chk("issue_baddr", bank_addr, v.baddr);
    n = 1;
    while (!rsp_valid && n < 25) begin
      @(posedge clk);
      #1;
      n++;
      chk("re_once", read_enable, 0);
    end
    req_valid = 1'b0;
    chk("rsp_latency", n, 4);
    chk("rsp_data", rsp_data, v.data);
    chk("rsp_bank", rsp_bank, v.bank);
    chk("hold_bsel", bank_select, v.bank);
    chk("hold_baddr", bank_addr, v.baddr);
    for (int i = 0; i < v.stall; i++) begin
      b0 = ~b0;
      b1 = b1 + 32'h1;
      b2 = ~b2;
      b3 = b3 ^ 32'h5A5A5A5A;
      @(posedge clk);
      #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdy", req_ready, 0);
      chk("stall_data", rsp_data, v.data);
      chk("stall_bank", rsp_bank, v.bank);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("done_rdy", req_ready, 1);
    chk("done_valid", rsp_valid, 0);
    set_banks(v);
  endtask

  initial begin
    int c, f1, f15, r1a, r1b, r15a, r15b;
    vt[0] = '{10'h2C5, 32'h0, 32'h1, 32'hDEADBEEF, 32'h3,
              2'd2, 8'hC5, 32'hDEADBEEF, 0};
    vt[1] = '{10'h012, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2,
              32'hD3D3D3D3, 2'd0, 8'h12, 32'hA0A0A0A0, 5};
    vt[2] = '{10'h1FF, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2,
              32'hD3D3D3D3, 2'd1, 8'hFF, 32'hB1B1B1B1, 0};
    vt[3] = '{10'h300, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2,
              32'hD3D3D3D3, 2'd3, 8'h00, 32'hD3D3D3D3, 2};
    vt[4] = '{10'h2AA, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2,
              32'hD3D3D3D3, 2'd2, 8'hAA, 32'hC2C2C2C2, 0};

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    rsp_ready = 1'b0;
    rv1 = 1'b0;
    rv15 = 1'b0;
    rr1 = 1'b1;
    rr15 = 1'b1;
    ra1 = 10'h3C0;
    ra15 = 10'h0C0;
    set_banks(vt[1]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_re", read_enable, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_bsel", bank_select, 0);
    chk("rst_baddr", bank_addr, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_bank", rsp_bank, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rdy", req_ready, 1);

    // Latency and back-to-back spacing on the L=1 and L=15 builds
    @(negedge clk);
    rv1 = 1'b1;
    rv15 = 1'b1;
    c = 0; f1 = 0; f15 = 0;
    r1a = 0; r1b = 0; r15a = 0; r15b = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      c++;
      if (vl1 && f1 == 0) f1 = c;
      if (vl15 && f15 == 0) f15 = c;
      if (re1) begin
        if (r1a == 0) r1a = c;
        else if (r1b == 0) r1b = c;
      end
      if (re15) begin
        if (r15a == 0) r15a = c;
        else if (r15b == 0) r15b = c;
      end
      if (f15 == c) chk("l15_data", rd15, 32'hA0A0A0A0);
      if (f1 == c) chk("l1_data", rd1, 32'hD3D3D3D3);
    end
    rv1 = 1'b0;
    rv15 = 1'b0;
    chk("l1_first", f1, 3);
    chk("l15_first", f15, 17);
    chk("l1_re_first", r1a, 1);
    chk("l1_spacing", r1b - r1a, 4);
    chk("l15_spacing", r15b - r15a, 18);

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // Reset while waiting on the bank: transaction is dropped
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 10'h1FF;
    @(posedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_re", read_enable, 0);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_bsel", bank_select, 0);
    chk("abort_baddr", bank_addr, 0);
    chk("abort_data", rsp_data, 0);
    chk("abort_bank", rsp_bank, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("abort_novalid", rsp_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle", {req_ready, rsp_valid}, 2'b10);
    end
    run_vec(vt[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bank_read_controller.md
BANK_READ_CONTROLLER -- requirements
Module: bank_read_controller

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, request address width; bits [ADDR_WIDTH-1:ADDR_WIDTH-2] select the bank, the remaining bits form the word address.
REQ-002 Parameter DATA_WIDTH, default 32, bank read-data width.
REQ-003 Parameter READ_LATENCY, default 2, legal range 1..15: cycles from the read_enable cycle to valid bank data.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  read request present.
REQ-007 req_ready  output  1  controller can accept a request.
REQ-008 req_addr  input  ADDR_WIDTH  request address.
REQ-009 bank_select  output  2  registered bank index, fed to the bank read-enable decoder.
REQ-010 read_enable  output  1  registered read strobe, fed to the bank read-enable decoder.
REQ-011 bank_addr  output  ADDR_WIDTH-2  registered word address, broadcast to all banks.
REQ-012 bank01_rdata..bank04_rdata  input  DATA_WIDTH each  read data from banks 0..3.
REQ-013 rsp_valid  output  1  response data valid.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_data  output  DATA_WIDTH  captured read data.
REQ-016 rsp_bank  output  2  bank index the response came from.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP; the reset state is IDLE.
REQ-018 req_ready SHALL be 1 only in IDLE; the controller SHALL NOT pipeline requests, so at most one read is outstanding.
REQ-019 In IDLE with req_valid=1: capture bank_select=req_addr[MSB:MSB-1] and bank_addr=req_addr[ADDR_WIDTH-3:0], then go to ISSUE.
REQ-020 In IDLE with req_valid=0: remain in IDLE; bank_select and bank_addr hold their previous values.
REQ-021 In ISSUE: read_enable=1 for exactly one cycle; load the latency counter with READ_LATENCY-1; go to WAIT.
REQ-022 read_enable SHALL be 0 in every state other than ISSUE.
REQ-023 In WAIT, while the counter is nonzero: decrement it by 1 each cycle.
REQ-024 In WAIT, when the counter is 0: capture the rdata of the bank given by the registered bank_select (never by the live req_addr) into rsp_data, set rsp_bank=bank_select, and go to RESP.
REQ-025 Bank data SHALL therefore be sampled at the end of cycle N+READ_LATENCY, where N is the read_enable cycle.
REQ-026 In RESP: rsp_valid=1; rsp_data and rsp_bank SHALL hold stable until rsp_ready=1; on that handshake cycle go to IDLE.
REQ-027 rsp_valid SHALL be 0 in all states other than RESP.
REQ-028 End-to-end latency: request accepted in cycle A, read_enable in A+1, rsp_valid first asserted in A+READ_LATENCY+2.
REQ-029 Minimum request spacing with rsp_ready held at 1: READ_LATENCY+3 cycles.
REQ-030 bank_select and bank_addr SHALL remain stable from ISSUE through RESP.
REQ-031 req_valid activity outside IDLE SHALL be ignored.
REQ-032 The counter SHALL be 4 bits wide; READ_LATENCY outside 1..15 is illegal and SHALL be flagged by a simulation-time assertion.

Reset
REQ-033 rst_n=0 SHALL immediately force: state=IDLE, req_ready=1 (once rst_n is released), read_enable=0, rsp_valid=0, bank_select=0, bank_addr=0, rsp_data=0, rsp_bank=0, counter=0.
REQ-034 Reset asserted during ISSUE, WAIT or RESP SHALL discard the transaction with no response; the first request after release SHALL behave as in REQ-028.
REQ-035 rst_n deassertion SHALL be synchronised externally; the block SHALL only require glitch-free release.

Verification
REQ-036 READ_LATENCY=2, req_addr=0x2C5 accepted in cycle A, bank03_rdata=0xDEADBEEF -> read_enable=1 in A+1 only, bank_select=2'b10, bank_addr=0x0C5, rsp_valid in A+4, rsp_data=0xDEADBEEF, rsp_bank=2.
REQ-037 Sweep all four banks with distinct rdata patterns, changing req_addr immediately after acceptance -> each rsp_data matches the bank captured at acceptance.
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP while the banks' rdata changes -> rsp_data, rsp_bank and rsp_valid stay stable and req_ready=0; rsp_ready=1 -> IDLE the next cycle.
REQ-039 Drive rst_n low during WAIT -> rsp_valid never asserts and all outputs take their reset values immediately; a new request completes normally.
REQ-040 READ_LATENCY=1 and READ_LATENCY=15 builds -> rsp_valid first asserted in A+3 and A+17 respectively; continuous req_valid gives one read_enable per READ_LATENCY+3 cycles.
